// File: rtl/hdmi_stream_scheduler.sv
// Raster-order pixel fetch scheduler feeding an AXI4-Stream video master.
// Requests are credit-limited so a 2-beat output buffer can never overflow.
module hdmi_stream_scheduler #(
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int LINE_GAP  = 16,
    parameter int FRAME_GAP = 64
) (
    input  logic        pixel_clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic        pix_req,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    input  logic [11:0] pix_rgb,
    output logic [23:0] tdata,
    output logic        tvalid,
    output logic        tuser,
    output logic        tlast,
    input  logic        tready,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_count
);

    localparam int GAP_MAX = (LINE_GAP > FRAME_GAP) ? LINE_GAP : FRAME_GAP;
    localparam int GAP_W   = $clog2(GAP_MAX) + 1;
    localparam int BEAT_W  = 27;

    localparam logic [9:0]       X_LAST    = 10'(H_RES - 1);
    localparam logic [9:0]       Y_LAST    = 10'(V_RES - 1);
    localparam logic [GAP_W-1:0] LGAP_LAST = GAP_W'(LINE_GAP - 1);
    localparam logic [GAP_W-1:0] FGAP_LAST = GAP_W'(FRAME_GAP - 1);
    localparam logic [GAP_W-1:0] GAP_ONE   = GAP_W'(1);

    typedef enum logic [1:0] {IDLE, ACTIVE, LGAP, FGAP} state_t;

    state_t            state_reg;
    logic [9:0]        x_reg;
    logic [9:0]        y_reg;
    logic [GAP_W-1:0]  gap_reg;

    logic              inflight_reg;
    logic              inflight_user_reg;
    logic              inflight_last_reg;
    logic              inflight_eof_reg;

    // Beat word layout: {end_of_frame, tlast, tuser, tdata}
    logic              out_valid_reg;
    logic [BEAT_W-1:0] out_beat_reg;
    logic              skid_valid_reg;
    logic [BEAT_W-1:0] skid_beat_reg;

    logic              frame_done_reg;
    logic [15:0]       frame_count_reg;

    logic [23:0]       rgb_expanded;
    logic [BEAT_W-1:0] captured_beat;
    logic [1:0]        occupancy;
    logic              credit;
    logic              pop;

    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        assign rgb_expanded[gi*8 +: 8] = {2{pix_rgb[gi*4 +: 4]}};
    end

    assign captured_beat = {inflight_eof_reg, inflight_last_reg, inflight_user_reg, rgb_expanded};

    // In-flight requests count against credit so the buffer always has room when data lands.
    assign occupancy = 2'(out_valid_reg) + 2'(skid_valid_reg) + 2'(inflight_reg);
    assign credit    = (occupancy < 2'd2);
    assign pop       = out_valid_reg & tready;

    assign pix_req     = (state_reg == ACTIVE) && credit;
    assign pix_x       = x_reg;
    assign pix_y       = y_reg;
    assign tvalid      = out_valid_reg;
    assign tdata       = out_beat_reg[23:0];
    assign tuser       = out_beat_reg[24];
    assign tlast       = out_beat_reg[25];
    assign busy        = (state_reg != IDLE) | inflight_reg | out_valid_reg | skid_valid_reg;
    assign frame_done  = frame_done_reg;
    assign frame_count = frame_count_reg;

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
            gap_reg   <= '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (enable) begin
                        state_reg <= ACTIVE;
                        x_reg     <= '0;
                        y_reg     <= '0;
                    end
                end
                ACTIVE: begin
                    if (pix_req) begin
                        if (x_reg == X_LAST) begin
                            x_reg   <= '0;
                            gap_reg <= '0;
                            if (y_reg == Y_LAST) begin
                                y_reg     <= '0;
                                state_reg <= FGAP;
                            end else begin
                                y_reg     <= y_reg + 10'd1;
                                state_reg <= LGAP;
                            end
                        end else begin
                            x_reg <= x_reg + 10'd1;
                        end
                    end
                end
                LGAP: begin
                    if (gap_reg == LGAP_LAST) begin
                        gap_reg   <= '0;
                        state_reg <= ACTIVE;
                    end else begin
                        gap_reg <= gap_reg + GAP_ONE;
                    end
                end
                FGAP: begin
                    if (gap_reg == FGAP_LAST) begin
                        gap_reg   <= '0;
                        state_reg <= enable ? ACTIVE : IDLE;
                    end else begin
                        gap_reg <= gap_reg + GAP_ONE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight_reg      <= 1'b0;
            inflight_user_reg <= 1'b0;
            inflight_last_reg <= 1'b0;
            inflight_eof_reg  <= 1'b0;
            out_valid_reg     <= 1'b0;
            out_beat_reg      <= '0;
            skid_valid_reg    <= 1'b0;
            skid_beat_reg     <= '0;
            frame_done_reg    <= 1'b0;
            frame_count_reg   <= '0;
        end else begin
            inflight_reg      <= pix_req;
            inflight_user_reg <= (x_reg == 10'd0) && (y_reg == 10'd0);
            inflight_last_reg <= (x_reg == X_LAST);
            inflight_eof_reg  <= (x_reg == X_LAST) && (y_reg == Y_LAST);

            // Output register is the head of the 2-beat queue; skid holds the second beat.
            if (pop) begin
                if (skid_valid_reg) begin
                    out_beat_reg   <= skid_beat_reg;
                    skid_valid_reg <= inflight_reg;
                    if (inflight_reg) begin
                        skid_beat_reg <= captured_beat;
                    end
                end else begin
                    out_valid_reg <= inflight_reg;
                    if (inflight_reg) begin
                        out_beat_reg <= captured_beat;
                    end
                end
            end else if (inflight_reg) begin
                if (!out_valid_reg) begin
                    out_valid_reg <= 1'b1;
                    out_beat_reg  <= captured_beat;
                end else begin
                    skid_valid_reg <= 1'b1;
                    skid_beat_reg  <= captured_beat;
                end
            end

            frame_done_reg <= pop & out_beat_reg[26];
            if (pop && out_beat_reg[26]) begin
                frame_count_reg <= frame_count_reg + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_stream_scheduler.sv
// Directed bench for hdmi_stream_scheduler: a queue-based model of the raster
// schedule and output buffer is compared against the DUT on every cycle.
module tb_hdmi_stream_scheduler;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int LG = 2;
    localparam int FG = 3;

    logic        pixel_clk = 1'b0;
    logic        reset_n   = 1'b0;
    logic        enable    = 1'b0;
    logic        tready    = 1'b0;
    logic [11:0] pix_rgb   = '0;
    logic        pix_req;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [23:0] tdata;
    logic        tvalid;
    logic        tuser;
    logic        tlast;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_count;

    hdmi_stream_scheduler #(
        .H_RES(H), .V_RES(V), .LINE_GAP(LG), .FRAME_GAP(FG)
    ) dut (
        .pixel_clk(pixel_clk), .reset_n(reset_n), .enable(enable),
        .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .tdata(tdata), .tvalid(tvalid), .tuser(tuser), .tlast(tlast), .tready(tready),
        .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
    );

    always #5 pixel_clk = ~pixel_clk;

    typedef struct {int x; int y; int f;} px_t;

    // Model: raster position, gap countdown, in-flight and buffered pixels as queues
    px_t         infl_q[$];
    px_t         beat_q[$];
    int          m_mode;      // 0 idle, 1 fetching, 2 gap
    bit          m_gap_frame;
    int          m_gap_left;
    int          m_x, m_y, m_frame;
    bit          m_fd;
    logic [15:0] m_fc;

    int n_checks = 0;
    int n_fail   = 0;

    bit src_pend = 0;
    int src_x, src_y, src_f;
    int src_frame = 0;

    int cyc = 0, beats_seen = 0, fd_seen = 0, first_tv = -1, user_beat = -1;
    logic [31:0] last_mask = '0;
    logic [23:0] first_data = '0, last_data = '0;
    logic        last_user = 1'b0;

    bit          prev_valid = 0, prev_ready = 0;
    logic [23:0] prev_data;
    logic        prev_user, prev_last;

    function automatic logic [11:0] color(int x, int y, int f);
        logic [11:0] v;
        v = {4'(f), 4'(y), 4'(x)};
        return 12'hA5C ^ v;
    endfunction

    function automatic logic [23:0] expand(logic [11:0] c);
        return {c[11:8], c[11:8], c[7:4], c[7:4], c[3:0], c[3:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        infl_q.delete();
        beat_q.delete();
        m_mode = 0; m_gap_frame = 0; m_gap_left = 0;
        m_x = 0; m_y = 0; m_fd = 0; m_fc = '0;
    endtask

    function automatic bit model_req();
        return (m_mode == 1) && (beat_q.size() + infl_q.size() < 2);
    endfunction

    task automatic model_step(input bit en, input bit rdy);
        bit  req;
        bit  pop;
        px_t p;
        req  = model_req();
        pop  = (beat_q.size() > 0) && rdy;
        m_fd = 0;
        if (pop) begin
            if (beat_q[0].x == H-1 && beat_q[0].y == V-1) begin
                m_fd = 1;
                m_fc = m_fc + 16'd1;
            end
            beat_q.delete(0);
        end
        if (infl_q.size() > 0) begin
            beat_q.push_back(infl_q[0]);
            infl_q.delete(0);
        end
        if (req) begin
            p.x = m_x; p.y = m_y; p.f = m_frame;
            infl_q.push_back(p);
        end
        if (m_mode == 0) begin
            if (en) m_mode = 1;
        end else if (m_mode == 1) begin
            if (req) begin
                if (m_x == H-1) begin
                    m_x = 0;
                    m_mode = 2;
                    if (m_y == V-1) begin
                        m_y = 0; m_gap_frame = 1; m_gap_left = FG; m_frame++;
                    end else begin
                        m_y++; m_gap_frame = 0; m_gap_left = LG;
                    end
                end else begin
                    m_x++;
                end
            end
        end else begin
            m_gap_left--;
            if (m_gap_left == 0) m_mode = (!m_gap_frame || en) ? 1 : 0;
        end
    endtask

    task automatic compare();
        bit  e_req;
        px_t b;
        e_req = model_req();
        chk("pix_req", pix_req, e_req);
        if (e_req) begin
            chk("pix_x", pix_x, m_x);
            chk("pix_y", pix_y, m_y);
        end
        chk("tvalid", tvalid, beat_q.size() > 0);
        if (beat_q.size() > 0) begin
            b = beat_q[0];
            chk("tdata", tdata, expand(color(b.x, b.y, b.f)));
            chk("tuser", tuser, (b.x == 0 && b.y == 0));
            chk("tlast", tlast, (b.x == H-1));
        end
        chk("busy", busy, (m_mode != 0) || infl_q.size() > 0 || beat_q.size() > 0);
        chk("frame_done", frame_done, m_fd);
        chk("frame_count", frame_count, m_fc);
        if (prev_valid && !prev_ready) begin
            chk("hold_tvalid", tvalid, 1);
            chk("hold_tdata", tdata, prev_data);
            chk("hold_tuser", tuser, prev_user);
            chk("hold_tlast", tlast, prev_last);
        end
    endtask

    // One clock: check at the falling edge, then drive inputs for the next rising edge.
    task automatic cycle(input bit en, input bit rdy, input bit rst);
        @(negedge pixel_clk);
        compare();
        if (tvalid && first_tv < 0) first_tv = cyc;
        if (frame_done) fd_seen++;
        if (tvalid && rdy && !rst) begin
            beats_seen++;
            last_data = tdata;
            last_user = tuser;
            if (beats_seen == 1) first_data = tdata;
            if (tuser && user_beat < 0) user_beat = beats_seen;
            if (tlast && beats_seen < 32) last_mask[beats_seen] = 1'b1;
            $display("beat %0d: tdata=%h tuser=%0d tlast=%0d", beats_seen, tdata, tuser, tlast);
        end
        prev_valid = tvalid && !rst;
        prev_ready = rdy;
        prev_data  = tdata;
        prev_user  = tuser;
        prev_last  = tlast;

        reset_n = !rst;
        enable  = en;
        tready  = rdy;
        pix_rgb = src_pend ? color(src_x, src_y, src_f) : 12'($urandom);
        src_pend = pix_req && !rst;
        if (pix_req) begin
            src_x = pix_x; src_y = pix_y; src_f = src_frame;
            if (pix_x == H-1 && pix_y == V-1) src_frame++;
        end
        if (rst) model_reset();
        else     model_step(en, rdy);
        cyc++;
    endtask

    task automatic drain_to_idle();
        for (int n = 0; n < 300 && busy; n++) cycle(0, 1, 0);
        chk("drain_idle", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c0, b0, f0, reqs;
        m_frame = 0;
        model_reset();
        repeat (3) cycle(0, 1, 1);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_count", frame_count, 0);
        repeat (2) cycle(0, 1, 0);

        // Single frame at full throughput
        cycle(1, 1, 0);
        c0 = cyc;
        for (int n = 0; n < 100 && fd_seen < 1; n++) cycle(1, 1, 0);
        chk("A_frame_done_once", fd_seen, 1);
        chk("A_beats", beats_seen, 8);
        chk("A_tuser_beat", user_beat, 1);
        chk("A_tlast_beats", last_mask, 32'h110);
        chk("A_frame_count", frame_count, 1);
        chk("A_first_tdata", first_data, 24'hAA55CC);
        chk("A_first_tvalid_latency", first_tv - c0 + 1, 3);
        drain_to_idle();

        // Random backpressure over three frames
        f0 = fd_seen;
        for (int n = 0; n < 3000 && fd_seen < f0 + 3; n++) cycle(1, 1'($urandom_range(0, 1)), 0);
        chk("B_frames", fd_seen - f0, 3);
        drain_to_idle();

        // Long stall mid-line
        for (int n = 0; n < 100 && !(pix_req && pix_x == 1); n++) cycle(1, 1, 0);
        chk("C_reach_x1", pix_req && pix_x == 1, 1);
        repeat (20) cycle(1, 0, 0);
        chk("C_model_occupancy", beat_q.size(), 2);
        chk("C_stall_tvalid", tvalid, 1);
        chk("C_stall_req", pix_req, 0);
        chk("C_stall_busy", busy, 1);
        drain_to_idle();

        // Enable dropped at pixel (1,0): frame still completes
        b0 = beats_seen;
        f0 = fd_seen;
        for (int n = 0; n < 100 && !(pix_req && pix_x == 1 && pix_y == 0); n++) cycle(1, 1, 0);
        chk("D_reach_1_0", pix_req && pix_x == 1 && pix_y == 0, 1);
        drain_to_idle();
        chk("D_beats", beats_seen - b0, 8);
        chk("D_frames", fd_seen - f0, 1);
        reqs = 0;
        repeat (10) begin
            cycle(0, 1, 0);
            if (pix_req) reqs++;
        end
        chk("D_no_req_after_idle", reqs, 0);

        // Reset with a full buffer mid-line
        for (int n = 0; n < 100 && !(pix_req && pix_x == 1); n++) cycle(1, 1, 0);
        repeat (4) cycle(1, 0, 0);
        chk("E_model_full", beat_q.size(), 2);
        chk("E_full_tvalid", tvalid, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("E_rst_pix_req", pix_req, 0);
        chk("E_rst_xy", {pix_x, pix_y}, 0);
        chk("E_rst_tvalid", tvalid, 0);
        chk("E_rst_tuser", tuser, 0);
        chk("E_rst_tlast", tlast, 0);
        chk("E_rst_tdata", tdata, 0);
        chk("E_rst_busy", busy, 0);
        chk("E_rst_frame_done", frame_done, 0);
        chk("E_rst_frame_count", frame_count, 0);
        model_reset();
        src_pend = 0;
        prev_valid = 0;
        repeat (2) cycle(0, 1, 1);
        b0 = beats_seen;
        for (int n = 0; n < 100 && beats_seen == b0; n++) cycle(1, 1, 0);
        chk("E_restart_beat", beats_seen - b0, 1);
        chk("E_restart_tuser", last_user, 1);
        drain_to_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
